mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Parametrised, synthesizable host-side load/dump engine for the pipeline's memory banks (IMEM, DMEM scalar, batch, encoded, ...). It replaces bench-only load/dump tasks with hardware that can also sit behind a host interface.
- Accepts a command (op, bank, base, length), then streams words into or out of one selected bank over valid/ready. It holds the pipeline enable low while any transfer is active.

Parameters:
- NUM_BANKS, 4, number of memory banks served (1..8)
- DATA_W, 32, bank word width; narrower banks use the low bits
- ADDR_W, 12, bank address width; depth = 2^ADDR_W
- BANK_W, 2, width of bank select; must satisfy 2^BANK_W >= NUM_BANKS

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, able to accept a command
- cmd_op  in  1  0 = load (write bank), 1 = dump (read bank)
- cmd_bank  in  BANK_W  target bank index
- cmd_base  in  ADDR_W  start address
- cmd_len  in  ADDR_W+1  word count; 0 = no-op
- wr_valid  in  1  load data offered
- wr_ready  out  1  load data accepted
- wr_data  in  DATA_W  load word
- rd_valid  out  1  dump word valid
- rd_ready  in  1  dump consumer ready
- rd_data  out  DATA_W  dump word
- rd_last  out  1  marks final dump word
- mem_addr  out  ADDR_W  shared bank address
- mem_wdata  out  DATA_W  shared write data
- mem_we  out  NUM_BANKS  one-hot write strobe
- mem_re  out  NUM_BANKS  one-hot read strobe
- mem_rdata  in  NUM_BANKS*DATA_W  bank read buses; bank k at [k*DATA_W +: DATA_W]; read latency 1
- pipe_en_req  in  1  requested pipeline enable
- pipe_en  out  1  pipe_en_req && !busy
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at command completion
- err  out  1  sticky bad-bank flag; cleared at next command accept

Behaviour:
- Reset: state IDLE. cmd_ready=1; wr_ready, rd_valid, rd_last, mem_we, mem_re, busy, done and err all 0. mem_addr, mem_wdata and rd_data are 0.
- Reset taken mid-transfer aborts the command at the next edge. There is no done pulse, and no strobe is asserted after that edge.
- States:
  - IDLE -> LOAD, DUMP_RD or FIN on cmd_valid && cmd_ready. The command is latched and err is cleared.
  - cmd_len=0 -> FIN.
  - cmd_bank >= NUM_BANKS -> FIN with err=1; no bank access.
  - cmd_len > 2^ADDR_W is clamped to 2^ADDR_W.
- LOAD:
  - wr_ready=1.
  - Each wr handshake registers mem_we[bank]=1, mem_addr=cur_addr and mem_wdata=wr_data, so the write lands one cycle after the handshake.
  - cur_addr increments modulo 2^ADDR_W (wraps 4095 -> 0); remaining count decrements.
  - After the last handshake, wr_ready drops and the state goes to FIN.
  - mem_we is 0 in cycles with no handshake.
- DUMP_RD: one cycle with mem_re[bank]=1 and mem_addr=cur_addr -> DUMP_CAP.
- DUMP_CAP: rd_data <= selected mem_rdata slice -> DUMP_OUT.
- DUMP_OUT:
  - rd_valid=1, with rd_data held stable until rd_ready.
  - rd_last=1 on the final word.
  - On handshake: if words remain, increment cur_addr (with wrap) and go to DUMP_RD; otherwise go to FIN.
  - Throughput is one word per 3 cycles plus any stall.
- FIN: done=1 for one cycle -> IDLE; cmd_ready returns the same cycle as the state change.
- cmd_valid while busy is ignored, since cmd_ready=0. wr_valid outside LOAD is ignored.
- mem_we and mem_re are never both nonzero. At most one bit of either vector is set.
- pipe_en is combinational from pipe_en_req and busy; it is forced 0 from the cycle after command accept through FIN.

Optional Feature:
- MEM_CHECKSUM_EN:
  - Defined: adds output port checksum (DATA_W), the sum modulo 2^DATA_W of every word written (LOAD) or emitted (DUMP) by the current command. It is cleared at command accept and valid once done pulses. A bad-bank command or cmd_len=0 leaves it 0.
  - Undefined: the port and its adder are absent; all other behaviour is identical.

Test Plan:
- Reset mid-LOAD: load bank 0, base 0, len 8; assert reset after 3 words -> next edge state IDLE, mem_we=0, no done pulse, cmd_ready=1.
- Load then dump: load bank 2, base 0x010, len 4 with 0x11,0x22,0x33,0x44, then dump the same range with rd_ready=1 -> rd_data 0x11,0x22,0x33,0x44; rd_last only on 0x44; done pulses once per command.
- Address wrap: load bank 1, base 0xFFE, len 4 -> writes to 0xFFE, 0xFFF, 0x000, 0x001; dump confirms.
- Backpressure: dump len 3 with rd_ready low for 5 cycles on word 1 -> rd_data stable while stalled; no extra mem_re until the handshake.
- Bad bank and zero length: cmd_bank=3 with NUM_BANKS=3 -> err=1, no strobes, done after 2 cycles. cmd_len=0 -> done, err=0. With MEM_CHECKSUM_EN, checksum=0 in both cases.
- Pipeline gating: pipe_en_req=1 throughout a len 2 load -> pipe_en=0 from the cycle after accept through FIN, then 1 again.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Purpose : host-side load/dump engine that streams words into or out of one
//           selected memory bank and holds the pipeline enable low while busy.
// Latency : load write lands 1 cycle after the wr handshake; dump is 1 word per
//           3 cycles (read, capture, present) plus any rd_ready stall.
// Backpressure: wr_ready high only in LOAD; rd_data held stable until rd_ready.
// Ports   : clk/reset (sync, active-high); cmd_* command channel (valid/ready);
//           wr_* load stream in; rd_* dump stream out with rd_last;
//           mem_* shared bank address/data with one-hot we/re strobes and the
//           concatenated bank read buses (1-cycle read latency);
//           pipe_en_req/pipe_en gating; busy, done (pulse), err (sticky bad bank).
// Option  : define MEM_CHECKSUM_EN to add the 'checksum' output, the modular sum
//           of all words written or emitted by the current command.
module mem_access_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int BANK_W    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_op,
  input  logic [BANK_W-1:0]           cmd_bank,
  input  logic [ADDR_W-1:0]           cmd_base,
  input  logic [ADDR_W:0]             cmd_len,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_last,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [NUM_BANKS-1:0]        mem_we,
  output logic [NUM_BANKS-1:0]        mem_re,
  input  logic [NUM_BANKS*DATA_W-1:0] mem_rdata,
  input  logic                        pipe_en_req,
  output logic                        pipe_en,
  output logic                        busy,
  output logic                        done,
`ifdef MEM_CHECKSUM_EN
  output logic [DATA_W-1:0]           checksum,
`endif
  output logic                        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DUMP_RD, S_DUMP_CAP, S_DUMP_OUT, S_FIN
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t                r_state, w_state_nxt;
  logic [BANK_W-1:0]     r_bank;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W:0]       r_rem;
  logic                  r_err;
  logic [NUM_BANKS-1:0]  r_we;
  logic [ADDR_W-1:0]     r_waddr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rd_data;

  logic                  w_accept, w_bank_ok, w_last, w_wr_hs, w_rd_hs;
  logic [ADDR_W:0]       w_len_clamped;
  logic [NUM_BANKS-1:0]  w_bank_oh;
  logic [DATA_W-1:0]     w_rdata_sel;

  assign w_accept      = cmd_valid && (r_state == S_IDLE);
  assign w_bank_ok     = int'(cmd_bank) < NUM_BANKS;
  assign w_len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign w_last        = (r_rem == (ADDR_W+1)'(1));
  assign w_wr_hs       = (r_state == S_LOAD) && wr_valid;
  assign w_rd_hs       = (r_state == S_DUMP_OUT) && rd_ready;

  // Bank decode and read-bus select from the latched bank index.
  always_comb begin
    w_bank_oh   = '0;
    w_rdata_sel = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (int'(r_bank) == k) begin
        w_bank_oh[k] = 1'b1;
        w_rdata_sel  = mem_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    mem_re      = '0;
    mem_addr    = r_waddr;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept) begin
          if (!w_bank_ok || (cmd_len == '0)) w_state_nxt = S_FIN;
          else if (cmd_op)                   w_state_nxt = S_DUMP_RD;
          else                               w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        wr_ready = 1'b1;
        if (w_wr_hs && w_last) w_state_nxt = S_FIN;
      end
      S_DUMP_RD: begin
        // Read address is driven straight from cur_addr in this cycle only.
        mem_re      = w_bank_oh;
        mem_addr    = r_addr;
        w_state_nxt = S_DUMP_CAP;
      end
      S_DUMP_CAP: w_state_nxt = S_DUMP_OUT;
      S_DUMP_OUT: begin
        rd_valid = 1'b1;
        rd_last  = w_last;
        if (rd_ready) w_state_nxt = w_last ? S_FIN : S_DUMP_RD;
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pipe_en   = pipe_en_req && !busy;
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;
  assign rd_data   = r_rd_data;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bank    <= '0;
      r_addr    <= '0;
      r_rem     <= '0;
      r_err     <= 1'b0;
      r_we      <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= '0;
      if (w_accept) begin
        r_bank <= cmd_bank;
        r_addr <= cmd_base;
        r_rem  <= w_len_clamped;
        r_err  <= !w_bank_ok;
      end
      // Write is registered so strobe, address and data reach the bank together.
      if (w_wr_hs) begin
        r_we    <= w_bank_oh;
        r_waddr <= r_addr;
        r_wdata <= wr_data;
        r_addr  <= r_addr + ADDR_W'(1);
        r_rem   <= r_rem - (ADDR_W+1)'(1);
      end
      if (r_state == S_DUMP_CAP) r_rd_data <= w_rdata_sel;
      if (w_rd_hs) begin
        r_rem <= r_rem - (ADDR_W+1)'(1);
        if (!w_last) r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

`ifdef MEM_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk) begin
    if (reset || w_accept) r_csum <= '0;
    else if (w_wr_hs)      r_csum <= r_csum + wr_data;
    else if (w_rd_hs)      r_csum <= r_csum + r_rd_data;
  end

  assign checksum = r_csum;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose : randomized self-checking bench for mem_access_ctrl against a bank
//           memory model and a reference image of what each bank should hold.
// Latency : inputs driven 1 time unit after posedge, outputs sampled after that.
// Backpressure: wr_valid gaps and rd_ready stalls are generated per scenario.
module tb_mem_access_ctrl;
  localparam int NB    = 3;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int BW    = 2;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, cmd_valid, cmd_ready, cmd_op;
  logic [BW-1:0]    cmd_bank;
  logic [AW-1:0]    cmd_base;
  logic [AW:0]      cmd_len;
  logic             wr_valid, wr_ready;
  logic [DW-1:0]    wr_data;
  logic             rd_valid, rd_ready, rd_last;
  logic [DW-1:0]    rd_data;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [NB-1:0]    mem_we, mem_re;
  logic [NB*DW-1:0] mem_rdata;
  logic             pipe_en_req, pipe_en, busy, done, err;
`ifdef MEM_CHECKSUM_EN
  logic [DW-1:0]    checksum;
`endif

  mem_access_ctrl #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .BANK_W(BW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bank(cmd_bank), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .pipe_en_req(pipe_en_req), .pipe_en(pipe_en),
    .busy(busy), .done(done),
`ifdef MEM_CHECKSUM_EN
    .checksum(checksum),
`endif
    .err(err)
  );

  // Bank memories with one-cycle registered read.
  bit   [DW-1:0] bank_mem [NB][DEPTH];
  logic [DW-1:0] rdq [NB];
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (mem_we[k]) bank_mem[k][mem_addr] <= mem_wdata;
      if (mem_re[k]) rdq[k] <= bank_mem[k][mem_addr];
    end
  end
  always_comb begin
    for (int k = 0; k < NB; k++) mem_rdata[k*DW +: DW] = rdq[k];
  end

  // Reference image: what each bank must contain after the accepted loads.
  bit   [DW-1:0] ref_mem [NB][DEPTH];
  logic [DW-1:0] load_q [$];

  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic op, input int bank, input int base, input int len);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin tick(); w++; end
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL cmd_ready_wait got %b want 1", cmd_ready); end
    cmd_op = op; cmd_bank = BW'(bank); cmd_base = AW'(base); cmd_len = (AW+1)'(len); cmd_valid = 1'b1;
    #1;
    vectors++;
    if (pipe_en !== 1'b1) begin miscompares++; $display("FAIL idle_pipe_en got %b want 1", pipe_en); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || pipe_en !== 1'b0 || cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL accept_busy busy=%b pipe_en=%b cmd_ready=%b want 1/0/0", busy, pipe_en, cmd_ready);
    end
  endtask

  task automatic run_load(input int bank, input int base, input int len, input bit gaps);
    int n = (len > DEPTH) ? DEPTH : len;
    int i = 0;
    int cyc = 0;
    int addr;
    logic hs;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_sum = '0;
    issue_cmd(1'b0, bank, base, len);
    while (i < n && cyc < n * 8 + 20) begin
      wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = (load_q.size() > 0) ? load_q[0] : $urandom;
      wr_data = d;
      #1;
      hs = wr_valid && wr_ready;
      vectors++;
      if (wr_ready !== 1'b1 || pipe_en !== 1'b0) begin
        miscompares++; $display("FAIL load_ready wr_ready=%b pipe_en=%b want 1/0", wr_ready, pipe_en);
      end
      tick();
      addr = (base + i) % DEPTH;
      if (hs) begin
        vectors++;
        if (mem_we !== NB'(1 << bank) || mem_addr !== AW'(addr) || mem_wdata !== d) begin
          miscompares++;
          $display("FAIL load_write we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                   mem_we, mem_addr, mem_wdata, NB'(1 << bank), AW'(addr), d);
        end
        ref_mem[bank][addr] = d;
        exp_sum += d;
        if (load_q.size() > 0) void'(load_q.pop_front());
        i++;
      end else begin
        vectors++;
        if (mem_we !== '0) begin miscompares++; $display("FAIL load_idle_we got %b want 0", mem_we); end
      end
      vectors++;
      if (mem_re !== '0 || done !== (i == n)) begin
        miscompares++; $display("FAIL load_done re=%b done=%b want re=0 done=%b", mem_re, done, (i == n));
      end
      cyc++;
    end
    wr_valid = 1'b0;
    vectors++;
    if (i != n) begin miscompares++; $display("FAIL load_timeout words=%0d want %0d", i, n); end
    vectors++;
    if (wr_ready !== 1'b0 || err !== 1'b0 || pipe_en !== 1'b0) begin
      miscompares++; $display("FAIL load_fin wr_ready=%b err=%b pipe_en=%b want 0/0/0", wr_ready, err, pipe_en);
    end
`ifdef MEM_CHECKSUM_EN
    vectors++;
    if (checksum !== exp_sum) begin miscompares++; $display("FAIL load_checksum got %h want %h", checksum, exp_sum); end
`endif
    tick();
    vectors++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || pipe_en !== 1'b1 || mem_we !== '0) begin
      miscompares++; $display("FAIL load_idle cmd_ready=%b done=%b pipe_en=%b we=%b want 1/0/1/0", cmd_ready, done, pipe_en, mem_we);
    end
  endtask

  task automatic run_dump(input int bank, input int base, input int len,
                          input int stall_word, input int stall_cycles, input bit rand_stall);
    int n = (len > DEPTH) ? DEPTH : len;
    int i = 0;
    int cyc = 0;
    int re_cnt = 0;
    int stalls = 0;
    int stall_left = stall_cycles;
    int addr;
    logic hs;
    logic stall;
    logic [DW-1:0] exp_sum = '0;
    issue_cmd(1'b1, bank, base, len);
    while (i < n && cyc < n * 20 + 40) begin
      stall = 1'b0;
      if (rd_valid === 1'b1) begin
        if (i == stall_word && stall_left > 0) begin stall = 1'b1; stall_left--; end
        else if (rand_stall && $urandom_range(0, 3) == 0) stall = 1'b1;
      end
      rd_ready = !stall;
      #1;
      addr = (base + i) % DEPTH;
      if (mem_re !== '0) begin
        re_cnt++;
        vectors++;
        if (mem_re !== NB'(1 << bank) || mem_addr !== AW'(addr) || mem_we !== '0) begin
          miscompares++; $display("FAIL dump_read re=%b addr=%h we=%b want re=%b addr=%h we=0",
                                  mem_re, mem_addr, mem_we, NB'(1 << bank), AW'(addr));
        end
      end
      if (rd_valid === 1'b1) begin
        vectors++;
        if (rd_data !== ref_mem[bank][addr] || rd_last !== (i == n - 1)) begin
          miscompares++; $display("FAIL dump_data word=%0d data=%h last=%b want data=%h last=%b",
                                  i, rd_data, rd_last, ref_mem[bank][addr], (i == n - 1));
        end
        vectors++;
        if (re_cnt != i + 1) begin miscompares++; $display("FAIL dump_re_count got %0d want %0d", re_cnt, i + 1); end
        if (stall) stalls++;
      end
      hs = rd_valid && rd_ready;
      vectors++;
      if (pipe_en !== 1'b0 || done !== 1'b0) begin
        miscompares++; $display("FAIL dump_busy pipe_en=%b done=%b want 0/0", pipe_en, done);
      end
      tick();
      if (hs) begin exp_sum += ref_mem[bank][addr]; i++; end
      cyc++;
    end
    rd_ready = 1'b0;
    vectors++;
    if (i != n || cyc != 3 * n + stalls) begin
      miscompares++; $display("FAIL dump_throughput words=%0d cycles=%0d want %0d/%0d", i, cyc, n, 3 * n + stalls);
    end
    vectors++;
    if (done !== 1'b1 || rd_valid !== 1'b0 || mem_re !== '0) begin
      miscompares++; $display("FAIL dump_fin done=%b rd_valid=%b re=%b want 1/0/0", done, rd_valid, mem_re);
    end
`ifdef MEM_CHECKSUM_EN
    vectors++;
    if (checksum !== exp_sum) begin miscompares++; $display("FAIL dump_checksum got %h want %h", checksum, exp_sum); end
`endif
    tick();
    vectors++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || pipe_en !== 1'b1) begin
      miscompares++; $display("FAIL dump_idle cmd_ready=%b done=%b pipe_en=%b want 1/0/1", cmd_ready, done, pipe_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl cmd_ready=%b busy=%b done=%b err=%b want 1/0/0/0", cmd_ready, busy, done, err);
    end
    vectors++;
    if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || mem_we !== '0 || mem_re !== '0) begin
      miscompares++; $display("FAIL reset_strobes wr_ready=%b rd_valid=%b rd_last=%b we=%b re=%b want all 0",
                              wr_ready, rd_valid, rd_last, mem_we, mem_re);
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0 || rd_data !== '0 || pipe_en !== 1'b1) begin
      miscompares++; $display("FAIL reset_data addr=%h wdata=%h rd_data=%h pipe_en=%b want 0/0/0/1",
                              mem_addr, mem_wdata, rd_data, pipe_en);
    end
`ifdef MEM_CHECKSUM_EN
    vectors++;
    if (checksum !== '0) begin miscompares++; $display("FAIL reset_checksum got %h want 0", checksum); end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    logic [DW-1:0] d;
    issue_cmd(1'b0, 0, 0, 8);
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      wr_valid = 1'b1; wr_data = d;
      tick();
      vectors++;
      if (mem_we !== NB'(1) || mem_addr !== AW'(i) || mem_wdata !== d) begin
        miscompares++; $display("FAIL midreset_write we=%b addr=%h data=%h want 001/%h/%h", mem_we, mem_addr, mem_wdata, AW'(i), d);
      end
      ref_mem[0][i] = d;
    end
    reset = 1'b1; wr_data = $urandom;
    tick();
    vectors++;
    if (cmd_ready !== 1'b1 || mem_we !== '0 || done !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0) begin
      miscompares++; $display("FAIL midreset_abort cmd_ready=%b we=%b done=%b busy=%b wr_ready=%b want 1/0/0/0/0",
                              cmd_ready, mem_we, done, busy, wr_ready);
    end
    reset = 1'b0; wr_valid = 1'b0;
    tick();
    vectors++;
    if (done !== 1'b0 || mem_we !== '0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL midreset_after done=%b we=%b cmd_ready=%b want 0/0/1", done, mem_we, cmd_ready);
    end
  endtask

  task automatic test_load_dump();
    load_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_load(2, 'h010, 4, 1'b0);
    run_dump(2, 'h010, 4, -1, 0, 1'b0);
  endtask

  task automatic test_addr_wrap();
    run_load(1, 'hFFE, 4, 1'b1);
    run_dump(1, 'hFFE, 4, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_dump(2, 'h010, 3, 1, 5, 1'b0);
  endtask

  task automatic test_bad_bank_zero_len();
    for (int op = 0; op < 2; op++) begin
      wr_valid = 1'b1; wr_data = $urandom;
      issue_cmd(op[0], 3, 'h20, 5);
      vectors++;
      if (err !== 1'b1 || done !== 1'b1 || mem_we !== '0 || mem_re !== '0 || wr_ready !== 1'b0) begin
        miscompares++; $display("FAIL badbank_fin op=%0d err=%b done=%b we=%b re=%b wr_ready=%b want 1/1/0/0/0",
                                op, err, done, mem_we, mem_re, wr_ready);
      end
`ifdef MEM_CHECKSUM_EN
      vectors++;
      if (checksum !== '0) begin miscompares++; $display("FAIL badbank_checksum got %h want 0", checksum); end
`endif
      tick();
      vectors++;
      if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b1 || mem_we !== '0) begin
        miscompares++; $display("FAIL badbank_sticky cmd_ready=%b done=%b err=%b we=%b want 1/0/1/0", cmd_ready, done, err, mem_we);
      end
      wr_valid = 1'b0;
    end
    issue_cmd(1'b0, 1, 'h30, 0);
    vectors++;
    if (err !== 1'b0 || done !== 1'b1 || mem_we !== '0 || mem_re !== '0) begin
      miscompares++; $display("FAIL zerolen_fin err=%b done=%b we=%b re=%b want 0/1/0/0", err, done, mem_we, mem_re);
    end
`ifdef MEM_CHECKSUM_EN
    vectors++;
    if (checksum !== '0) begin miscompares++; $display("FAIL zerolen_checksum got %h want 0", checksum); end
`endif
    tick();
    vectors++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL zerolen_idle cmd_ready=%b done=%b want 1/0", cmd_ready, done);
    end
  endtask

  task automatic test_pipe_gating();
    run_load(0, 'h100, 2, 1'b0);
  endtask

  task automatic test_len_clamp();
    run_load(0, 5, 8191, 1'b0);
    run_dump(0, 4, 3, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    int bank, base, len;
    for (int t = 0; t < 8; t++) begin
      bank = $urandom_range(0, NB - 1);
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(1, 6);
      run_load(bank, base, len, 1'b1);
      run_dump(bank, base, len, -1, 0, 1'b1);
      run_dump($urandom_range(0, NB - 1), $urandom_range(0, DEPTH - 1), $urandom_range(1, 4), -1, 0, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_bank = '0; cmd_base = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; pipe_en_req = 1'b1;
    test_reset();
    test_reset_mid_load();
    test_load_dump();
    test_addr_wrap();
    test_backpressure();
    test_bad_bank_zero_len();
    test_pipe_gating();
    test_len_clamp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
